// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types, digit limits and helper functions for the
// stopwatch/lap timer core.
//   state_t      : top-level FSM states
//   bcd_t        : one 4-bit BCD digit
//   bcd_time_t   : packed {Ht,Ho,Mt,Mo,St,So}
//   digit_step   : one-digit increment/decrement with carry/borrow out
//   preset_valid : range check of a BCD preset against the hour modulus
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  typedef logic [3:0]  bcd_t;
  typedef logic [23:0] bcd_time_t;

  localparam bcd_t      DIG_MAX9  = 4'd9;
  localparam bcd_t      DIG_MAX5  = 4'd5;
  localparam bcd_time_t TIME_ZERO = 24'h000000;
  localparam bcd_time_t TIME_ONE  = 24'h000001;

  // Returns {carry_or_borrow, next_digit}. Up: lim wraps to 0 with carry.
  // Down: 0 wraps to lim with borrow.
  function automatic logic [4:0] digit_step(bcd_t d, bcd_t lim, logic down);
    logic wrap_d;
    bcd_t nxt;
    if (down) begin
      wrap_d = (d == 4'd0);
      nxt    = wrap_d ? lim : (d - 4'd1);
    end else begin
      wrap_d = (d == lim);
      nxt    = wrap_d ? 4'd0 : (d + 4'd1);
    end
    return {wrap_d, nxt};
  endfunction

  // A preset is usable when every digit is decimal, tens of minutes and
  // seconds are 0..5, and the two hour digits form a value below hour_mod.
  function automatic logic preset_valid(bcd_time_t t, int hour_mod);
    int hours;
    hours = int'(t[23:20]) * 32'sd10 + int'(t[19:16]);
    return (t[23:20] <= DIG_MAX9) && (t[19:16] <= DIG_MAX9) &&
           (t[15:12] <= DIG_MAX5) && (t[11:8]  <= DIG_MAX9) &&
           (t[7:4]   <= DIG_MAX5) && (t[3:0]   <= DIG_MAX9) &&
           (hours < hour_mod);
  endfunction

endpackage

// File: rtl/stopwatch_lap_timer_bcd_time_counter.sv
// bcd_time_counter: HH:MM:SS BCD counter with carry/borrow chain.
//   clk, rst      : clock, asynchronous active-high reset
//   tick          : advance one second in direction dir (0 up, 1 down)
//   load/load_val : synchronous load of a (pre-validated) BCD time
//   count         : current BCD time
//   at_zero       : count is 00:00:00
//   at_max        : count is (HOUR_MOD-1):59:59
module bcd_time_counter
  import stopwatch_pkg::*;
#(
  parameter int HOUR_MOD = 24
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      tick,
  input  logic      dir,
  input  logic      load,
  input  bcd_time_t load_val,
  output bcd_time_t count,
  output logic      at_zero,
  output logic      at_max
);

  localparam bcd_t      HT_MAX   = bcd_t'((HOUR_MOD - 1) / 10);
  localparam bcd_t      HO_MAX   = bcd_t'((HOUR_MOD - 1) % 10);
  localparam bcd_time_t TIME_MAX = {HT_MAX, HO_MAX, 4'd5, 4'd9, 4'd5, 4'd9};

  bcd_time_t  count_r;
  bcd_time_t  next_s;
  logic [4:0] so_s, st_s, mo_s, mt_s;
  logic       c1_s, c2_s, c3_s, c4_s;
  logic [7:0] hr_up_s, hr_dn_s;

  // Next-value carry/borrow chain; hours wrap at HOUR_MOD rather than 99.
  always_comb begin
    next_s  = count_r;
    so_s    = digit_step(count_r[3:0],   DIG_MAX9, dir);
    st_s    = digit_step(count_r[7:4],   DIG_MAX5, dir);
    mo_s    = digit_step(count_r[11:8],  DIG_MAX9, dir);
    mt_s    = digit_step(count_r[15:12], DIG_MAX5, dir);
    c1_s    = so_s[4];
    c2_s    = c1_s & st_s[4];
    c3_s    = c2_s & mo_s[4];
    c4_s    = c3_s & mt_s[4];
    hr_up_s = (count_r[23:16] == {HT_MAX, HO_MAX}) ? 8'h00 :
              (count_r[19:16] == DIG_MAX9) ? {count_r[23:20] + 4'd1, 4'd0} :
              {count_r[23:20], count_r[19:16] + 4'd1};
    hr_dn_s = (count_r[23:16] == 8'h00) ? {HT_MAX, HO_MAX} :
              (count_r[19:16] == 4'd0) ? {count_r[23:20] - 4'd1, DIG_MAX9} :
              {count_r[23:20], count_r[19:16] - 4'd1};
    next_s[3:0]   = so_s[3:0];
    next_s[7:4]   = c1_s ? st_s[3:0] : count_r[7:4];
    next_s[11:8]  = c2_s ? mo_s[3:0] : count_r[11:8];
    next_s[15:12] = c3_s ? mt_s[3:0] : count_r[15:12];
    next_s[23:16] = c4_s ? (dir ? hr_dn_s : hr_up_s) : count_r[23:16];
  end

  // Count register: load has priority; tick advances; otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= TIME_ZERO;
    end else if (load) begin
      count_r <= load_val;
    end else if (tick) begin
      count_r <= next_s;
    end else begin
      count_r <= count_r;
    end
  end

  assign count   = count_r;
  assign at_zero = (count_r == TIME_ZERO);
  assign at_max  = (count_r == TIME_MAX);

endmodule

// File: rtl/stopwatch_lap_timer.sv
// stopwatch_lap_timer: BCD HH:MM:SS stopwatch / countdown with lap freeze.
//   clk, clr   : clock, asynchronous active-high clear
//   go, stop   : start (level) / stop counting
//   lap        : pulse; capture+freeze in RUN, release otherwise
//   mode_down  : direction, latched when counting starts
//   load/preset: pulse + BCD value to load in IDLE or EXPIRED
//   digits     : registered display value (lap value while frozen)
//   running    : in RUN;  lap_frozen : display shows the lap value
//   wrap       : pulse on up-count rollover; expired : pulse on reaching 0
//   load_err   : pulse when a load is rejected as out of range
module stopwatch_lap_timer
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int HOUR_MOD = 24
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        go,
  input  logic        stop,
  input  logic        lap,
  input  logic        mode_down,
  input  logic        load,
  input  logic [23:0] preset,
  output logic [23:0] digits,
  output logic        running,
  output logic        lap_frozen,
  output logic        wrap,
  output logic        expired,
  output logic        load_err
);

  localparam int                 PRESC_W    = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  state_t             state_r, next_state_s;
  logic [PRESC_W-1:0] presc_r;
  logic               dir_r;
  bcd_time_t          lap_r, count_s, digits_r;
  logic               lap_frozen_r, running_r, wrap_r, expired_r, load_err_r;
  logic               tick_s, start_s, load_ok_s, load_bad_s, expire_s, wrap_s;
  logic               at_zero_s, at_max_s, preset_ok_s;

  assign preset_ok_s = preset_valid(preset, HOUR_MOD);
  assign tick_s      = (state_r == RUN) && (presc_r == PRESC_LAST);
  assign wrap_s      = tick_s && !dir_r && at_max_s;

  // Next-state and control strobes; load beats go in IDLE, expiry beats stop.
  always_comb begin
    next_state_s = state_r;
    start_s      = 1'b0;
    load_ok_s    = 1'b0;
    load_bad_s   = 1'b0;
    expire_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (load) begin
          load_ok_s  = preset_ok_s;
          load_bad_s = !preset_ok_s;
        end else if (go && !stop && !(mode_down && at_zero_s)) begin
          next_state_s = RUN;
          start_s      = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (tick_s && dir_r && (count_s == TIME_ONE)) begin
          next_state_s = EXPIRED;
          expire_s     = 1'b1;
        end else if (stop) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RUN;
        end
      end
      EXPIRED: begin
        if (load) begin
          load_ok_s    = preset_ok_s;
          load_bad_s   = !preset_ok_s;
          next_state_s = preset_ok_s ? IDLE : EXPIRED;
        end else begin
          next_state_s = EXPIRED;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, prescaler, direction, lap capture and registered outputs.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r      <= IDLE;
      presc_r      <= '0;
      dir_r        <= 1'b0;
      lap_r        <= TIME_ZERO;
      lap_frozen_r <= 1'b0;
      digits_r     <= TIME_ZERO;
      running_r    <= 1'b0;
      wrap_r       <= 1'b0;
      expired_r    <= 1'b0;
      load_err_r   <= 1'b0;
    end else begin
      state_r <= next_state_s;
      if (start_s || load_ok_s) begin
        presc_r <= '0;
      end else if (state_r == RUN) begin
        presc_r <= tick_s ? '0 : presc_r + PRESC_W'(1);
      end else begin
        presc_r <= presc_r;
      end
      dir_r <= start_s ? mode_down : dir_r;
      // Capture uses the pre-tick count because count_s is the old register value.
      if ((state_r == RUN) && lap) begin
        lap_r        <= count_s;
        lap_frozen_r <= 1'b1;
      end else if ((state_r != RUN) && (lap || load_ok_s)) begin
        lap_r        <= lap_r;
        lap_frozen_r <= 1'b0;
      end else begin
        lap_r        <= lap_r;
        lap_frozen_r <= lap_frozen_r;
      end
      digits_r   <= lap_frozen_r ? lap_r : count_s;
      running_r  <= (next_state_s == RUN);
      wrap_r     <= wrap_s;
      expired_r  <= expire_s;
      load_err_r <= load_bad_s;
    end
  end

  bcd_time_counter #(
    .HOUR_MOD (HOUR_MOD)
  ) u_counter (
    .clk      (clk),
    .rst      (clr),
    .tick     (tick_s),
    .dir      (dir_r),
    .load     (load_ok_s),
    .load_val (preset),
    .count    (count_s),
    .at_zero  (at_zero_s),
    .at_max   (at_max_s)
  );

  assign digits     = digits_r;
  assign running    = running_r;
  assign lap_frozen = lap_frozen_r;
  assign wrap       = wrap_r;
  assign expired    = expired_r;
  assign load_err   = load_err_r;

endmodule
